count_sequencer: RTL and testbench

//   Synchronous controller that sequences a modulo-N counter datapath.
//   It loads the modulus, direction and run count on a start request, then

---
 rtl/count_sequencer.sv | 175 +++++++++++++++++
 tb/tb_count_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Controller for a modulo-N counter: loads modulus/direction/run count on start,
// steps once per clock, and pulses done after the programmed number of wraps.
module count_sequencer #(
  parameter int WIDTH  = 5,
  parameter int RUNS_W = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [WIDTH-1:0]  modulus,
  input  logic [RUNS_W-1:0] runs,
  input  logic              up,
  input  logic              hold,
  input  logic              abort,
  output logic [WIDTH-1:0]  count,
  output logic              wrap,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [RUNS_W-1:0] runs_left
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]  ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  ONE_W  = WIDTH'(1);
  localparam logic [WIDTH-1:0]  TWO_W  = WIDTH'(2);
  localparam logic [RUNS_W-1:0] ZERO_R = {RUNS_W{1'b0}};
  localparam logic [RUNS_W-1:0] ONE_R  = RUNS_W'(1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  mod_q, mod_d;
  logic [RUNS_W-1:0] runs_q, runs_d;
  logic [RUNS_W-1:0] runs_left_q, runs_left_d;
  logic              up_q, up_d;
  logic              wrap_q, wrap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  step_count_s;
  logic              step_wrap_s;

  // Next count value and wrap flag for one step in the latched direction.
  always_comb begin
    step_count_s = count_q;
    step_wrap_s  = 1'b0;
    if (up_q) begin
      if (count_q == (mod_q - ONE_W)) begin
        step_count_s = ZERO_W;
        step_wrap_s  = 1'b1;
      end else begin
        step_count_s = count_q + ONE_W;
      end
    end else begin
      if (count_q == ZERO_W) begin
        step_count_s = mod_q - ONE_W;
        step_wrap_s  = 1'b1;
      end else begin
        step_count_s = count_q - ONE_W;
      end
    end
  end

  // Sequencer next-state and next-output logic; abort outranks hold outranks step.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mod_d       = mod_q;
    runs_d      = runs_q;
    up_d        = up_q;
    runs_left_d = runs_left_q;
    busy_d      = busy_q;
    wrap_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (modulus >= TWO_W) begin
            state_d     = S_RUN;
            mod_d       = modulus;
            up_d        = up;
            runs_d      = runs;
            count_d     = up ? ZERO_W : (modulus - ONE_W);
            runs_left_d = runs;
            busy_d      = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN, S_HOLD: begin
        if (abort) begin
          state_d     = S_IDLE;
          count_d     = ZERO_W;
          runs_left_d = ZERO_R;
          busy_d      = 1'b0;
        end else if (state_q == S_HOLD) begin
          state_d = hold ? S_HOLD : S_RUN;
        end else if (hold) begin
          state_d = S_HOLD;
        end else begin
          count_d = step_count_s;
          wrap_d  = step_wrap_s;
          // runs of zero means wrap forever with runs_left parked at zero
          if (step_wrap_s && (runs_q != ZERO_R)) begin
            runs_left_d = runs_left_q - ONE_R;
            if (runs_left_q == ONE_R) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d     = S_IDLE;
        count_d     = ZERO_W;
        runs_left_d = ZERO_R;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and registered outputs; clear wins over everything.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= S_IDLE;
      count_q     <= ZERO_W;
      mod_q       <= ZERO_W;
      runs_q      <= ZERO_R;
      up_q        <= 1'b0;
      runs_left_q <= ZERO_R;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mod_q       <= mod_d;
      runs_q      <= runs_d;
      up_q        <= up_d;
      runs_left_q <= runs_left_d;
      wrap_q      <= wrap_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign count     = count_q;
  assign wrap      = wrap_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign runs_left = runs_left_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: step-count reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_count_sequencer;

  localparam int WIDTH  = 5;
  localparam int RUNS_W = 4;

  logic              clock = 1'b0;
  logic              clear = 1'b1;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  modulus = '0;
  logic [RUNS_W-1:0] runs = '0;
  logic              up = 1'b0;
  logic              hold = 1'b0;
  logic              abort = 1'b0;
  logic [WIDTH-1:0]  count;
  logic              wrap, busy, done, err;
  logic [RUNS_W-1:0] runs_left;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference: an active sequence is described by how many steps it has taken.
  int m_active = 0, m_held = 0, m_done = 0, m_err = 0, m_wrap = 0;
  int m_n = 0, m_up = 0, m_runs = 0, m_steps = 0, m_idle_cnt = 0;

  count_sequencer #(.WIDTH(WIDTH), .RUNS_W(RUNS_W)) dut (
    .clock(clock), .clear(clear), .start(start), .modulus(modulus),
    .runs(runs), .up(up), .hold(hold), .abort(abort), .count(count),
    .wrap(wrap), .busy(busy), .done(done), .err(err), .runs_left(runs_left)
  );

  always #5 clock = ~clock;

  function automatic int m_count();
    if (m_active != 0)
      return (m_up != 0) ? (m_steps % m_n) : (m_n - 1 - (m_steps % m_n));
    return m_idle_cnt;
  endfunction

  function automatic int m_runs_left();
    if (m_active != 0 && m_runs != 0)
      return m_runs - (m_steps / m_n);
    return 0;
  endfunction

  task automatic model_update();
    m_wrap = 0;
    m_err  = 0;
    if (clear) begin
      m_active = 0; m_held = 0; m_done = 0; m_idle_cnt = 0;
      m_n = 0; m_up = 0; m_runs = 0; m_steps = 0;
    end else if (m_done != 0) begin
      m_done = 0;
    end else if (m_active == 0) begin
      if (start) begin
        if (int'(modulus) >= 2) begin
          m_active = 1; m_held = 0; m_steps = 0;
          m_n = int'(modulus); m_up = int'(up); m_runs = int'(runs);
        end else begin
          m_err = 1;
        end
      end
    end else if (abort) begin
      m_active = 0; m_held = 0; m_idle_cnt = 0;
    end else if (m_held != 0) begin
      if (!hold) m_held = 0;
    end else if (hold) begin
      m_held = 1;
    end else begin
      m_steps++;
      if (m_steps % m_n == 0) begin
        m_wrap = 1;
        if (m_runs != 0 && m_steps / m_n == m_runs) begin
          m_idle_cnt = m_count();
          m_active = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("count", int'(count), m_count());
    chk("wrap", int'(wrap), m_wrap);
    chk("busy", int'(busy), m_active);
    chk("done", int'(done), m_done);
    chk("err", int'(err), m_err);
    chk("runs_left", int'(runs_left), m_runs_left());
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic go(input int n_mod, input int dir, input int n_runs);
    modulus = WIDTH'(n_mod);
    up      = dir[0];
    runs    = RUNS_W'(n_runs);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    // reset held for two cycles
    ticks(2);
    clear = 1'b0;
    tick();
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_runs_left", int'(runs_left), 0);

    // N=10 up, two wraps; input changes while busy must be ignored
    go(10, 1, 2);
    chk("t2_first", int'(count), 0);
    chk("t2_runs_left", int'(runs_left), 2);
    modulus = 5'd3; up = 1'b0; runs = 4'd7; start = 1'b1;
    ticks(10);
    chk("t2_wrap1", int'(wrap), 1);
    chk("t2_left1", int'(runs_left), 1);
    start = 1'b0;
    ticks(10);
    chk("t2_done", int'(done), 1);
    chk("t2_done_busy", int'(busy), 0);
    chk("t2_done_count", int'(count), 0);
    tick();
    chk("t2_after_done", int'(done), 0);

    // N=9 down, one wrap
    go(9, 0, 1);
    chk("t3_first", int'(count), 8);
    ticks(9);
    chk("t3_done", int'(done), 1);
    chk("t3_wrap", int'(wrap), 1);
    chk("t3_count", int'(count), 8);
    tick();

    // hold for three cycles at count 4
    go(10, 1, 0);
    ticks(4);
    hold = 1'b1;
    ticks(3);
    chk("t4_hold_count", int'(count), 4);
    chk("t4_hold_busy", int'(busy), 1);
    hold = 1'b0;
    ticks(2);
    chk("t4_resume", int'(count), 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // infinite run, abort at count 3 after seven wraps
    go(5, 1, 0);
    ticks(38);
    chk("t5_count", int'(count), 3);
    chk("t5_left", int'(runs_left), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_count", int'(count), 0);
    chk("t5_abort_done", int'(done), 0);
    tick();

    // illegal moduli, then clear mid-run
    go(1, 1, 1);
    chk("t6_err", int'(err), 1);
    chk("t6_busy", int'(busy), 0);
    tick();
    chk("t6_err_gone", int'(err), 0);
    go(0, 0, 1);
    chk("t6_err0", int'(err), 1);
    go(10, 1, 0);
    ticks(6);
    chk("t6_pre_clear", int'(count), 6);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_clear_count", int'(count), 0);
    chk("t6_clear_busy", int'(busy), 0);

    // all-ones modulus counting down, abort racing the final wrap
    go(31, 0, 1);
    chk("max_first", int'(count), 30);
    ticks(30);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("race_done", int'(done), 0);
    chk("race_count", int'(count), 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      clear   = ($urandom_range(0, 299) == 0);
      abort   = ($urandom_range(0, 79) == 0);
      hold    = ($urandom_range(0, 9) == 0);
      start   = ($urandom_range(0, 3) == 0);
      up      = 1'($urandom_range(0, 1));
      modulus = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom_range(0, 31))
                                            : WIDTH'($urandom_range(0, 9));
      runs    = RUNS_W'($urandom_range(0, 3));
      tick();
    end
    clear = 1'b0; abort = 1'b0; hold = 1'b0; start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
